// File: rtl/muntjac_pkg.sv
// Shared frontend types for the Muntjac core.
//   if_reason_e   : why the frontend issued a fetch
//   exc_cause_e   : exception cause codes (instruction-side subset)
//   fetch_entry_t : one complete fetch record (request side + response side),
//                   the unit of storage in the fetch queue and the unit the
//                   instruction aligner consumes.
package muntjac_pkg;

    typedef enum logic [3:0] {
        IF_PREFETCH     = 4'h0,
        IF_PREDICT      = 4'h1,
        IF_MISPREDICT   = 4'h2,
        IF_PROT_CHANGED = 4'h3,
        IF_SATP_CHANGED = 4'h4,
        IF_FENCE_I      = 4'h5
    } if_reason_e;

    typedef enum logic [3:0] {
        EXC_CAUSE_INSN_ADDR_MISA     = 4'd0,
        EXC_CAUSE_INSTR_ACCESS_FAULT = 4'd1,
        EXC_CAUSE_ILLEGAL_INSN       = 4'd2,
        EXC_CAUSE_BREAKPOINT         = 4'd3,
        EXC_CAUSE_INSTR_PAGE_FAULT   = 4'd12
    } exc_cause_e;

    // Widest PC a fetch entry can carry; narrower PCs are zero-extended.
    localparam int unsigned FetchPcMax = 64;

    typedef struct packed {
        logic [FetchPcMax-1:0] pc;
        if_reason_e            reason;
        logic [1:0]            strb;
        logic [31:0]           instr;
        logic                  exception;
        exc_cause_e            ex_code;
    } fetch_entry_t;

endpackage

// File: rtl/muntjac_fetch_queue.sv
// Fetch-response queue between the I$ interface and the instruction aligner.
// Up to Depth requests may be outstanding. A request reserves an entry
// (pc/reason/strb); the in-order response later fills it (instr/exception/
// ex_code); the aligner pops filled entries from the head. After a redirect
// flush, responses belonging to the old epoch are discarded by a drop counter.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_ready_o                        a new I$ request may be issued
//   req_valid_i/pc/reason/strb         I$ request issued this cycle
//   resp_valid_i/instr/exception/code  I$ response (always accepted)
//   flush_i                            discard all queued and in-flight fetches
//   out_valid_o/out_ready_i            head entry handshake to the aligner
//   out_pc/reason/strb/instr/exception/ex_code_o  head entry fields
module muntjac_fetch_queue
    import muntjac_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter bit          FallThrough = 1'b1,
    parameter int unsigned PcLen       = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    output logic             req_ready_o,
    input  logic             req_valid_i,
    input  logic [PcLen-1:0] req_pc_i,
    input  if_reason_e       req_reason_i,
    input  logic [1:0]       req_strb_i,

    input  logic             resp_valid_i,
    input  logic [31:0]      resp_instr_i,
    input  logic             resp_exception_i,
    input  exc_cause_e       resp_ex_code_i,

    input  logic             flush_i,

    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PcLen-1:0] out_pc_o,
    output if_reason_e       out_reason_o,
    output logic [1:0]       out_strb_o,
    output logic [31:0]      out_instr_o,
    output logic             out_exception_o,
    output exc_cause_e       out_ex_code_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;             // pointer with wrap bit
    localparam int unsigned DW = $clog2(Depth + 1);  // drop counter holds 0..Depth
    localparam int unsigned SW = ((PW > DW) ? PW : DW) + 1;

    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_rd;
    logic [DW-1:0] r_drop_cnt;
    fetch_entry_t  r_mem [Depth];

    logic [PW-1:0] w_occupancy;
    logic [PW-1:0] w_unfilled;
    logic [SW-1:0] w_budget;
    logic          w_fire;
    logic          w_dropping;
    logic          w_resp_take;
    logic          w_empty;
    logic          w_ft;
    logic          w_pop;
    logic          w_store;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_fill_idx;
    logic [AW-1:0] w_rd_idx;
    logic [Depth-1:0] w_wr_en;
    logic [Depth-1:0] w_fill_en;
    fetch_entry_t  w_head;

    assign w_occupancy = r_wr - r_rd;
    assign w_unfilled  = r_wr - r_fill;

    // Entries owed to stale responses still count against capacity, so the
    // I$ can never have more than Depth requests in flight.
    assign w_budget    = SW'(w_occupancy) + SW'(r_drop_cnt);
    assign req_ready_o = (w_budget < SW'(Depth));
    assign w_fire      = req_valid_i && req_ready_o;

    assign w_dropping  = (r_drop_cnt != '0);
    assign w_resp_take = resp_valid_i && !w_dropping && !flush_i;
    assign w_empty     = (r_rd == r_fill);

    // Fall-through: the response is for the head entry (nothing filled ahead
    // of it), so it can be presented directly with the reserved pc fields.
    assign w_ft = FallThrough && w_empty && (w_unfilled != '0) && !w_dropping
                  && resp_valid_i && !flush_i;

    assign out_valid_o = !flush_i && (!w_empty || w_ft);
    assign w_pop       = out_valid_o && out_ready_i;

    // A fall-through response consumed in the same cycle never needs storing.
    assign w_store     = w_resp_take && !(w_ft && out_ready_i);

    // A request in the flush cycle starts the new epoch at entry 0.
    assign w_wr_idx   = flush_i ? '0 : r_wr[AW-1:0];
    assign w_fill_idx = r_fill[AW-1:0];
    assign w_rd_idx   = r_rd[AW-1:0];

    for (genvar gi = 0; gi < Depth; gi++) begin : g_en
        assign w_wr_en[gi]   = w_fire  && (w_wr_idx   == AW'(gi));
        assign w_fill_en[gi] = w_store && (w_fill_idx == AW'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr       <= '0;
            r_fill     <= '0;
            r_rd       <= '0;
            r_drop_cnt <= '0;
        end else if (flush_i) begin
            r_wr       <= PW'(w_fire);
            r_fill     <= '0;
            r_rd       <= '0;
            // Every unfilled reservation becomes a stale response; one arriving
            // right now is the oldest of them and is consumed immediately.
            r_drop_cnt <= r_drop_cnt + DW'(w_unfilled) - DW'(resp_valid_i);
        end else begin
            r_wr       <= r_wr   + PW'(w_fire);
            r_fill     <= r_fill + PW'(w_resp_take);
            r_rd       <= r_rd   + PW'(w_pop);
            r_drop_cnt <= r_drop_cnt - DW'(resp_valid_i && w_dropping);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (w_wr_en[i]) begin
                    r_mem[i].pc     <= FetchPcMax'(req_pc_i);
                    r_mem[i].reason <= req_reason_i;
                    r_mem[i].strb   <= req_strb_i;
                end
                if (w_fill_en[i]) begin
                    r_mem[i].instr     <= resp_instr_i;
                    r_mem[i].exception <= resp_exception_i;
                    r_mem[i].ex_code   <= resp_ex_code_i;
                end
            end
        end
    end

    // When empty, rd == fill, so the head slot is also the slot the
    // fall-through response belongs to.
    assign w_head          = r_mem[w_rd_idx];
    assign out_pc_o        = w_head.pc[PcLen-1:0];
    assign out_reason_o    = w_head.reason;
    assign out_strb_o      = w_head.strb;
    assign out_instr_o     = w_ft ? resp_instr_i     : w_head.instr;
    assign out_exception_o = w_ft ? resp_exception_i : w_head.exception;
    assign out_ex_code_o   = w_ft ? resp_ex_code_i   : w_head.ex_code;

    // A response with nothing outstanding and nothing to drop is an I$ bug.
    a_resp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_valid_i && !w_dropping && (w_unfilled == '0)));

endmodule

// File: tb/tb_muntjac_fetch_queue.sv
module tb_muntjac_fetch_queue;
    import muntjac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [63:0] req_pc;
    if_reason_e  req_reason;
    logic [1:0]  req_strb;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        resp_exc;
    exc_cause_e  resp_code;
    logic        flush;
    logic        out_ready;

    logic        o_req_ready [2];
    logic        o_valid     [2];
    logic [63:0] o_pc        [2];
    if_reason_e  o_reason    [2];
    logic [1:0]  o_strb      [2];
    logic [31:0] o_instr     [2];
    logic        o_exc       [2];
    exc_cause_e  o_code      [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: no fall-through. Instance 1: fall-through enabled.
    muntjac_fetch_queue #(.Depth(4), .FallThrough(1'b0), .PcLen(64)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_ready_o(o_req_ready[0]), .req_valid_i(req_valid), .req_pc_i(req_pc),
        .req_reason_i(req_reason), .req_strb_i(req_strb),
        .resp_valid_i(resp_valid), .resp_instr_i(resp_instr),
        .resp_exception_i(resp_exc), .resp_ex_code_i(resp_code),
        .flush_i(flush), .out_valid_o(o_valid[0]), .out_ready_i(out_ready),
        .out_pc_o(o_pc[0]), .out_reason_o(o_reason[0]), .out_strb_o(o_strb[0]),
        .out_instr_o(o_instr[0]), .out_exception_o(o_exc[0]), .out_ex_code_o(o_code[0])
    );

    muntjac_fetch_queue #(.Depth(4), .FallThrough(1'b1), .PcLen(64)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_ready_o(o_req_ready[1]), .req_valid_i(req_valid), .req_pc_i(req_pc),
        .req_reason_i(req_reason), .req_strb_i(req_strb),
        .resp_valid_i(resp_valid), .resp_instr_i(resp_instr),
        .resp_exception_i(resp_exc), .resp_ex_code_i(resp_code),
        .flush_i(flush), .out_valid_o(o_valid[1]), .out_ready_i(out_ready),
        .out_pc_o(o_pc[1]), .out_reason_o(o_reason[1]), .out_strb_o(o_strb[1]),
        .out_instr_o(o_instr[1]), .out_exception_o(o_exc[1]), .out_ex_code_o(o_code[1])
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] pc;
        if_reason_e  reason;
        logic [1:0]  strb;
        logic [31:0] instr;
        logic        exc;
        exc_cause_e  code;
    } ent_t;

    typedef struct {
        int          at;
        logic [63:0] pc;
        logic [31:0] instr;
    } pop_t;

    ent_t pend_q [2][$];   // requests of the current epoch awaiting a response
    ent_t stor_q [2][$];   // completed entries awaiting the aligner
    int   drop   [2];      // stale responses still to come
    pop_t log_q  [2][$];   // observed pops, for hand-computed pins

    bit   exp_ready [2];
    bit   exp_valid [2];
    ent_t exp_ent   [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: expected outputs from the current model contents and inputs.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                exp_ready[m] = (pend_q[m].size() + stor_q[m].size() + drop[m]) < 4;
                exp_valid[m] = 1'b0;
                if (!flush) begin
                    if (stor_q[m].size() > 0) begin
                        exp_valid[m] = 1'b1;
                        exp_ent[m]   = stor_q[m][0];
                    end else if (m == 1 && resp_valid && drop[m] == 0 && pend_q[m].size() > 0) begin
                        exp_valid[m]       = 1'b1;
                        exp_ent[m]         = pend_q[m][0];
                        exp_ent[m].instr   = resp_instr;
                        exp_ent[m].exc     = resp_exc;
                        exp_ent[m].code    = resp_code;
                    end
                end
                chk($sformatf("dut%0d.req_ready", m), 64'(o_req_ready[m]), 64'(exp_ready[m]));
                chk($sformatf("dut%0d.out_valid", m), 64'(o_valid[m]), 64'(exp_valid[m]));
                if (exp_valid[m]) begin
                    chk($sformatf("dut%0d.pc", m),     o_pc[m],            exp_ent[m].pc);
                    chk($sformatf("dut%0d.reason", m), 64'(o_reason[m]),   64'(exp_ent[m].reason));
                    chk($sformatf("dut%0d.strb", m),   64'(o_strb[m]),     64'(exp_ent[m].strb));
                    chk($sformatf("dut%0d.instr", m),  64'(o_instr[m]),    64'(exp_ent[m].instr));
                    chk($sformatf("dut%0d.exc", m),    64'(o_exc[m]),      64'(exp_ent[m].exc));
                    chk($sformatf("dut%0d.code", m),   64'(o_code[m]),     64'(exp_ent[m].code));
                end
                if (o_valid[m] && out_ready)
                    log_q[m].push_back('{cyc, o_pc[m], o_instr[m]});
            end
        end
    end

    // Model state update at the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                pend_q[m].delete();
                stor_q[m].delete();
                drop[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                ent_t e;
                if (flush) begin
                    drop[m] = drop[m] + pend_q[m].size() - (resp_valid ? 1 : 0);
                    pend_q[m].delete();
                    stor_q[m].delete();
                end else begin
                    if (resp_valid) begin
                        if (drop[m] > 0) begin
                            drop[m]--;
                        end else if (pend_q[m].size() > 0) begin
                            e       = pend_q[m].pop_front();
                            e.instr = resp_instr;
                            e.exc   = resp_exc;
                            e.code  = resp_code;
                            stor_q[m].push_back(e);
                        end
                    end
                    if (exp_valid[m] && out_ready && stor_q[m].size() > 0)
                        void'(stor_q[m].pop_front());
                end
                if (req_valid && exp_ready[m]) begin
                    e.pc = req_pc; e.reason = req_reason; e.strb = req_strb;
                    e.instr = '0; e.exc = 1'b0; e.code = EXC_CAUSE_INSN_ADDR_MISA;
                    pend_q[m].push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; resp_valid = 1'b0; flush = 1'b0;
        resp_exc = 1'b0; resp_code = EXC_CAUSE_INSN_ADDR_MISA;
    endtask

    task automatic req(input logic [63:0] pc, input if_reason_e r, input logic [1:0] s);
        req_valid = 1'b1; req_pc = pc; req_reason = r; req_strb = s;
    endtask

    task automatic resp(input logic [31:0] instr, input logic exc, input exc_cause_e c);
        resp_valid = 1'b1; resp_instr = instr; resp_exc = exc; resp_code = c;
    endtask

    task automatic clear_logs();
        log_q[0].delete();
        log_q[1].delete();
    endtask

    task automatic pin_pop(input int m, input int idx, input int at, input logic [63:0] pc,
                           input logic [31:0] instr, input string tag);
        if (idx >= log_q[m].size()) begin
            chk($sformatf("%s.dut%0d.pops", tag, m), 64'(log_q[m].size()), 64'(idx + 1));
        end else begin
            chk($sformatf("%s.dut%0d.pop%0d.cycle", tag, m, idx), 64'(log_q[m][idx].at), 64'(at));
            chk($sformatf("%s.dut%0d.pop%0d.pc", tag, m, idx), log_q[m][idx].pc, pc);
            chk($sformatf("%s.dut%0d.pop%0d.instr", tag, m, idx), 64'(log_q[m][idx].instr), 64'(instr));
        end
    endtask

    int base;

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        req_pc = '0; req_reason = IF_PREFETCH; req_strb = 2'b00; resp_instr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset.dut%0d.valid", m), 64'(o_valid[m]), 64'd0);
            chk($sformatf("reset.dut%0d.ready", m), 64'(o_req_ready[m]), 64'd1);
            chk($sformatf("reset.dut%0d.pc", m), o_pc[m], 64'd0);
            chk($sformatf("reset.dut%0d.instr", m), 64'(o_instr[m]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // 1: four back-to-back requests, responses at latency 2.
        $display("test1: streaming, latency 2");
        clear_logs(); base = cyc;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 4) req(64'(4 * i), if_reason_e'(4'(i)), 2'(i + 1));
            if (i >= 2) resp(32'hA0 + 32'(i - 2), (i == 3), (i == 3) ? EXC_CAUSE_INSTR_PAGE_FAULT
                                                                      : EXC_CAUSE_INSN_ADDR_MISA);
            tick();
        end
        idle(); repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            pin_pop(0, k, base + 3 + k, 64'(4 * k), 32'hA0 + 32'(k), "t1");
            pin_pop(1, k, base + 2 + k, 64'(4 * k), 32'hA0 + 32'(k), "t1");
        end

        // 2: aligner stalled with four filled entries.
        $display("test2: full queue, stalled aligner");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) req(64'(4 * i), IF_PREDICT, 2'b11);
            if (i >= 1) resp(32'hB0 + 32'(i - 1), 1'b0, EXC_CAUSE_INSN_ADDR_MISA);
            tick();
        end
        idle();
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("t2.dut%0d.ready_full", m), 64'(o_req_ready[m]), 64'd0);
                chk($sformatf("t2.dut%0d.pc_hold", m), o_pc[m], 64'h0);
            end
            tick();
        end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("t2.dut%0d.pc_next", m), o_pc[m], 64'h4);
            chk($sformatf("t2.dut%0d.ready_after_pop", m), 64'(o_req_ready[m]), 64'd1);
        end
        out_ready = 1'b1; repeat (4) tick();

        // 3: flush with two unfilled, then a new-epoch request.
        $display("test3: flush drops two stale responses");
        clear_logs(); base = cyc;
        req(64'h0, IF_PREFETCH, 2'b01); tick();
        idle(); req(64'h4, IF_PREFETCH, 2'b01); tick();
        idle(); flush = 1'b1; tick();
        idle(); req(64'h100, IF_MISPREDICT, 2'b10); tick();
        idle(); resp(32'hD0, 1'b0, EXC_CAUSE_INSN_ADDR_MISA); tick();
        idle(); resp(32'hD1, 1'b0, EXC_CAUSE_INSN_ADDR_MISA); tick();
        idle(); resp(32'hD2, 1'b1, EXC_CAUSE_INSTR_ACCESS_FAULT); tick();
        idle(); repeat (3) tick();
        pin_pop(0, 0, base + 7, 64'h100, 32'hD2, "t3");
        pin_pop(1, 0, base + 6, 64'h100, 32'hD2, "t3");
        chk("t3.dut0.pop_count", 64'(log_q[0].size()), 64'd1);

        // 4: flush, response and request all in one cycle.
        $display("test4: flush with concurrent response and request");
        clear_logs(); base = cyc;
        req(64'h0, IF_PREFETCH, 2'b01); tick();
        idle(); req(64'h4, IF_PREFETCH, 2'b01); tick();
        idle(); flush = 1'b1; resp(32'hE0, 1'b0, EXC_CAUSE_INSN_ADDR_MISA);
        req(64'h200, IF_FENCE_I, 2'b11); tick();
        idle(); resp(32'hE1, 1'b0, EXC_CAUSE_INSN_ADDR_MISA); tick();
        idle(); resp(32'hE2, 1'b0, EXC_CAUSE_INSN_ADDR_MISA); tick();
        idle(); repeat (3) tick();
        pin_pop(0, 0, base + 5, 64'h200, 32'hE2, "t4");
        pin_pop(1, 0, base + 4, 64'h200, 32'hE2, "t4");
        chk("t4.dut1.pop_count", 64'(log_q[1].size()), 64'd1);

        // 5: fall-through versus registered path.
        $display("test5: fall-through latency");
        clear_logs(); base = cyc;
        req(64'h500, IF_PREDICT, 2'b10); tick();
        idle(); resp(32'hF0, 1'b0, EXC_CAUSE_INSN_ADDR_MISA);
        #1;
        chk("t5.dut1.valid_same_cycle", 64'(o_valid[1]), 64'd1);
        chk("t5.dut0.valid_same_cycle", 64'(o_valid[0]), 64'd0);
        tick();
        idle(); tick();
        chk("t5.dut1.empty_after", 64'(o_valid[1]), 64'd0);
        tick();
        pin_pop(1, 0, base + 1, 64'h500, 32'hF0, "t5");
        pin_pop(0, 0, base + 2, 64'h500, 32'hF0, "t5");

        // 6: asynchronous reset with three reserved entries and one pending drop.
        $display("test6: reset mid-operation");
        out_ready = 1'b0;
        req(64'h600, IF_PREFETCH, 2'b01); tick();
        idle(); flush = 1'b1; req(64'h610, IF_PREFETCH, 2'b01); tick();
        idle(); req(64'h620, IF_PREFETCH, 2'b01); tick();
        idle(); req(64'h630, IF_PREFETCH, 2'b01); tick();
        idle();
        chk("t6.dut0.ready_before_reset", 64'(o_req_ready[0]), 64'd0);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("t6.dut%0d.valid_in_reset", m), 64'(o_valid[m]), 64'd0);
            chk($sformatf("t6.dut%0d.ready_in_reset", m), 64'(o_req_ready[m]), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        clear_logs(); base = cyc;
        req(64'h700, IF_PREFETCH, 2'b11); tick();
        idle(); resp(32'hC0, 1'b0, EXC_CAUSE_INSN_ADDR_MISA); tick();
        idle(); repeat (2) tick();
        pin_pop(0, 0, base + 2, 64'h700, 32'hC0, "t6");
        pin_pop(1, 0, base + 1, 64'h700, 32'hC0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
